// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: front stage of the bit-serial adder.
// Accepts an operand pair a/b on a valid/ready handshake, issues a one-cycle
// carry-clear pulse, then streams both operands LSB-first, one bit pair per
// cycle, to the adder's x/y inputs. Every output comes straight from a flop.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = in reset)
//   in_valid   operand pair a/b is valid
//   in_ready   feeder can accept a pair this cycle
//   a, b       WIDTH-bit operands, sampled on accept
//   clr        carry-clear pulse to the adder, high for exactly one cycle
//   x, y       current bit of A / B
//   bit_valid  x/y carry a live operand bit
//   bit_last   x/y carry the MSB of the word
module serial_operand_feeder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             clr,
    output logic             x,
    output logic             y,
    output logic             bit_valid,
    output logic             bit_last
);

    localparam int unsigned CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);

    // The shift index and the last-bit lookahead need at least two bits per word.
    generate
        if (WIDTH < 2) begin : g_width_check
            $error("serial_operand_feeder: WIDTH must be >= 2");
        end
    endgenerate

    localparam logic [CW-1:0] IDX_LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] IDX_PRE_LAST = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0] sa_q, sa_n;
    logic [WIDTH-1:0] sb_q, sb_n;

    logic in_ready_n, clr_n, x_n, y_n, bit_valid_n, bit_last_n;

    // State, datapath and output registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sa_q      <= '0;
            sb_q      <= '0;
            in_ready  <= 1'b0;
            clr       <= 1'b0;
            x         <= 1'b0;
            y         <= 1'b0;
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            sa_q      <= sa_n;
            sb_q      <= sb_n;
            in_ready  <= in_ready_n;
            clr       <= clr_n;
            x         <= x_n;
            y         <= y_n;
            bit_valid <= bit_valid_n;
            bit_last  <= bit_last_n;
        end
    end

    // Next state plus the output values for the cycle after this edge.
    // cnt_q is the index of the bit currently on x/y while in SHIFT.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        sa_n        = sa_q;
        sb_n        = sb_q;
        in_ready_n  = 1'b0;
        clr_n       = 1'b0;
        x_n         = 1'b0;
        y_n         = 1'b0;
        bit_valid_n = 1'b0;
        bit_last_n  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // in_ready is low for the first cycle out of reset, so gate on it.
                if (in_valid && in_ready) begin
                    state_n = CLEAR;
                    sa_n    = a;
                    sb_n    = b;
                    clr_n   = 1'b1;
                end else begin
                    in_ready_n = 1'b1;
                end
            end

            CLEAR: begin
                state_n     = SHIFT;
                cnt_n       = '0;
                x_n         = sa_q[0];
                y_n         = sb_q[0];
                bit_valid_n = 1'b1;
                sa_n        = sa_q >> 1;
                sb_n        = sb_q >> 1;
            end

            SHIFT: begin
                if (cnt_q == IDX_LAST) begin
                    state_n    = IDLE;
                    in_ready_n = 1'b1;
                end else begin
                    cnt_n       = cnt_q + CW'(1);
                    x_n         = sa_q[0];
                    y_n         = sb_q[0];
                    bit_valid_n = 1'b1;
                    bit_last_n  = (cnt_q == IDX_PRE_LAST);
                    sa_n        = sa_q >> 1;
                    sb_n        = sb_q >> 1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: a timeline model (edges since accept) predicts
// every output each cycle; a word checker reassembles x/y and runs a bit-serial
// adder to compare against a+b.
module tb_serial_operand_feeder;

    localparam int W = 8;
    localparam int DEPTH = 4096;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         clr;
    logic         x;
    logic         y;
    logic         bit_valid;
    logic         bit_last;

    serial_operand_feeder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .clr       (clr),
        .x         (x),
        .y         (y),
        .bit_valid (bit_valid),
        .bit_last  (bit_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // d = edges since the accept edge: d=1 is the clear cycle, d=2..W+1 carry bits 0..W-1.
    logic         m_active;
    logic         m_ready;
    int           m_d;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    int           cyc;
    int           acc_cnt;
    logic [W-1:0] exp_a   [DEPTH];
    logic [W-1:0] exp_b   [DEPTH];
    int           acc_cyc [DEPTH];
    int           wr_idx;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 1'b0;
            m_ready  = 1'b0;
            m_d      = 0;
        end else begin
            cyc++;
            if (!m_active) begin
                if (m_ready && in_valid) begin
                    m_active = 1'b1;
                    m_ready  = 1'b0;
                    m_d      = 1;
                    m_a      = a;
                    m_b      = b;
                    exp_a[wr_idx % DEPTH]   = a;
                    exp_b[wr_idx % DEPTH]   = b;
                    acc_cyc[wr_idx % DEPTH] = cyc;
                    wr_idx++;
                    acc_cnt++;
                end else begin
                    m_ready = 1'b1;
                end
            end else if (m_d == W + 1) begin
                m_active = 1'b0;
                m_ready  = 1'b1;
            end else begin
                m_d++;
            end
        end
    end

    // ---------------- per-cycle compare + word checker ----------------
    int           rd_idx;
    int           nb;
    logic         carry;
    logic [W-1:0] xw, yw, sw;
    logic [W-1:0] last_x, last_y, last_s;
    logic         checking;

    always @(negedge clk) begin
        logic [5:0] expv;
        logic [5:0] actv;
        int idx;
        expv = '0;
        if (m_active) begin
            if (m_d == 1) expv[4] = 1'b1;
            else begin
                idx = m_d - 2;
                expv[3] = m_a[idx];
                expv[2] = m_b[idx];
                expv[1] = 1'b1;
                expv[0] = (idx == W - 1);
            end
        end else begin
            expv[5] = m_ready;
        end
        actv = {in_ready, clr, x, y, bit_valid, bit_last};
        if (checking) chk("cycle {rdy,clr,x,y,bv,last}", 32'(actv), 32'(expv));

        if (!reset) begin
            nb     = 0;
            carry  = 1'b0;
            rd_idx = wr_idx;
        end else begin
            if (clr) carry = 1'b0;
            if (bit_valid) begin
                if (nb < W) begin
                    xw[nb] = x;
                    yw[nb] = y;
                    sw[nb] = x ^ y ^ carry;
                end
                carry = (x & y) | (carry & (x ^ y));
                nb++;
                if (bit_last) begin
                    chk("word bit count", 32'(nb), 32'(W));
                    chk("word x==a", 32'(xw), 32'(exp_a[rd_idx % DEPTH]));
                    chk("word y==b", 32'(yw), 32'(exp_b[rd_idx % DEPTH]));
                    chk("word sum", 32'(sw),
                        32'(W'(exp_a[rd_idx % DEPTH] + exp_b[rd_idx % DEPTH])));
                    last_x = xw;
                    last_y = yw;
                    last_s = sw;
                    rd_idx++;
                    nb = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input int gap);
        int start;
        int t;
        start = acc_cnt;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        a = va;
        b = vb;
        while (acc_cnt == start && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (acc_cnt == start) chk("accept timeout", 32'(acc_cnt), 32'(start + 1));
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((rd_idx != wr_idx || m_active) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (rd_idx != wr_idx) chk("drain timeout", 32'(rd_idx), 32'(wr_idx));
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        reset    = 1'b0;
        in_valid = 1'b1;
        a        = 8'h5A;
        b        = 8'hC3;
        checking = 1'b0;
        cyc      = 0;
        acc_cnt  = 0;
        wr_idx   = 0;
        #1 checking = 1'b1;

        // 1: reset held 3 cycles with in_valid high
        repeat (3) @(negedge clk);
        chk("reset outputs", 32'({in_ready, clr, x, y, bit_valid, bit_last}), 32'd0);
        reset = 1'b1;
        #1 chk("in_ready before first edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 chk("in_ready after first edge", 32'(in_ready), 32'd1);
        chk("no accept on first edge", 32'(acc_cnt), 32'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        // 2: basic word
        send(8'hA5, 8'h3C, 2);
        wait_drain();
        chk("A5 x word", 32'(last_x), 32'h0A5);
        chk("3C y word", 32'(last_y), 32'h03C);
        chk("A5+3C sum", 32'(last_s), 32'h0E1);

        // 3: back-pressure with in_valid held and a/b churning
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h22;
        p = acc_cnt;
        while (acc_cnt == p) begin @(posedge clk); #1; end
        repeat (4) begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
        end
        @(negedge clk);
        a = 8'h33;
        b = 8'h44;
        while (acc_cnt == p + 1 && cyc < 100000) begin @(posedge clk); #1; end
        chk("back-pressure period", 32'(acc_cyc[(wr_idx - 1) % DEPTH] - acc_cyc[(wr_idx - 2) % DEPTH]), 32'd10);
        chk("second pair a", 32'(exp_a[(wr_idx - 1) % DEPTH]), 32'h33);
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain();
        chk("33+44 sum", 32'(last_s), 32'h077);

        // 4: carry isolation
        send(8'hFF, 8'hFF, 0);
        send(8'h00, 8'h00, 0);
        wait_drain();
        chk("00+00 after FF+FF", 32'(last_s), 32'h000);

        // 5: mid-word reset at bit index 3
        send(8'hC7, 8'h9E, 0);
        p = 0;
        while (!(m_active && m_d == 5) && p < 50) begin @(posedge clk); #1; p++; end
        chk("at bit 3 bit_valid", 32'(bit_valid), 32'd1);
        #2 reset = 1'b0;
        #1 chk("async reset outputs", 32'({in_ready, clr, x, y, bit_valid, bit_last}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h01, 8'h01, 0);
        wait_drain();
        chk("01+01 after reset", 32'(last_s), 32'h002);

        // 6: random pairs with random gaps
        for (int i = 0; i < 1000; i++) begin
            send(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
        end
        wait_drain();
        chk("all words checked", 32'(rd_idx), 32'(wr_idx));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
